// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 definitions for the accumulate/reduce datapath.
// Holds the subtractor FSM state encoding, FP32 field widths, canonical
// special encodings, and the unpack/pack helpers. Denormals unpack to
// exponent 1 with a zero hidden bit so they align like the smallest normal.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_ADDSUB = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Exponent carries one extra bit so exp+1 overflow past 254 is visible.
    typedef struct packed {
        logic [EXP_W:0] exp;
        logic [MAN_W:0] man;
    } unpacked_t;

    function automatic unpacked_t fp_unpack(input logic [31:0] x);
        unpacked_t u;
        if (x[30:23] == 8'd0) begin
            u.exp = 9'd1;
            u.man = {1'b0, x[22:0]};
        end else begin
            u.exp = {1'b0, x[30:23]};
            u.man = {1'b1, x[22:0]};
        end
        return u;
    endfunction

    // m[23] is the hidden bit. Exponent 1 with hidden bit clear is a denormal.
    function automatic logic [31:0] fp_pack(input logic s,
                                            input logic [EXP_W:0] e,
                                            input logic [MAN_W:0] m);
        logic [31:0] r;
        if (e >= 9'd255)
            r = POS_INF | {s, 31'd0};
        else if (e == 9'd1 && !m[23])
            r = {s, 8'd0, m[22:0]};
        else
            r = {s, e[7:0], m[22:0]};
        return r;
    endfunction

endpackage

// File: rtl/fp32_lzc.sv
// fp32_lzc: combinational 24-bit leading-zero counter.
// Ports:
//   x     in  24  value to scan (bit 23 is the most significant)
//   count out 5   number of leading zeros, 24 when x is zero
module fp32_lzc (
    input  logic [23:0] x,
    output logic [4:0]  count
);
    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (x[i]) count = 5'(23 - i);
        end
    end
endmodule

// File: rtl/fp32_subtractor.sv
// fp32_subtractor: sequential IEEE-754 single-precision subtractor, o = a - b.
// Build option: define FP32_SUB_RNE_EN to carry guard/round/sticky bits and
// add a ROUND state (round-to-nearest-even); otherwise results truncate.
// Parameter NORM_STEP (1, 2 or 4): maximum left shift per NORM cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  high only in IDLE
//   a, b       in   minuend, subtrahend (FP32)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts
//   o          out  difference (FP32), stable while out_valid
//   fsm_state  out  current FSM state (state_t encoding) for observation
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the producer holds its data stable while valid waits for ready.
module fp32_subtractor #(
    parameter int NORM_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] o,
    output logic [2:0]  fsm_state
);
    import fp32_pkg::*;

    // Working mantissa: [27] carry, [26] hidden, [25:3] fraction, [2:0] G/R/S.
    // Without rounding the G/R/S bits are masked to zero, which is exactly
    // truncation of the aligned operand.
`ifdef FP32_SUB_RNE_EN
    localparam logic [2:0] GRS_MASK = 3'b111;
`else
    localparam logic [2:0] GRS_MASK = 3'b000;
`endif

    state_t      state;
    logic        sa, sb;
    logic [8:0]  ea, eb;
    logic [27:0] ma, mb;

    // Special-case detection on the raw inputs.
    unpacked_t   ua, ub;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
    logic [31:0] special_val;

    assign ua     = fp_unpack(a);
    assign ub     = fp_unpack(b);
    assign a_nan  = (&a[30:23]) && (a[22:0] != 23'd0);
    assign b_nan  = (&b[30:23]) && (b[22:0] != 23'd0);
    assign a_inf  = (&a[30:23]) && (a[22:0] == 23'd0);
    assign b_inf  = (&b[30:23]) && (b[22:0] == 23'd0);
    assign a_zero = (a[30:0] == 31'd0);
    assign b_zero = (b[30:0] == 31'd0);

    always_comb begin
        special     = 1'b1;
        special_val = 32'd0;
        if (a_nan || b_nan)                      special_val = QNAN;
        else if (a_inf && b_inf && a[31] == b[31]) special_val = QNAN;
        else if (a_inf)                          special_val = a;
        else if (b_inf || a_zero)                special_val = {~b[31], b[30:0]};
        else if (b_zero)                         special_val = a;
        else                                     special     = 1'b0;
    end

    // ALIGN: pick the larger exponent as base, shift the other right.
    logic        a_big;
    logic [8:0]  big_e, diff;
    logic [27:0] small_m, shifted, lost_mask, aligned;
    logic [4:0]  sh;

    always_comb begin
        a_big     = (ea >= eb);
        big_e     = a_big ? ea : eb;
        diff      = a_big ? (ea - eb) : (eb - ea);
        small_m   = a_big ? mb : ma;
        sh        = (diff > 9'd28) ? 5'd28 : diff[4:0];
        shifted   = small_m >> sh;
        lost_mask = (28'd1 << sh) - 28'd1;
        aligned   = {shifted[27:1], shifted[0] | (|(small_m & lost_mask))}
                    & {25'h1FFFFFF, GRS_MASK};
    end

    // ADDSUB: magnitude add or subtract; sign follows the larger magnitude.
    logic [27:0] as_res;
    logic        as_sign;

    always_comb begin
        if (sa == sb) begin
            as_res  = ma + mb;
            as_sign = sa;
        end else if (ma >= mb) begin
            as_res  = ma - mb;
            as_sign = sa;
        end else begin
            as_res  = mb - ma;
            as_sign = sb;
        end
    end

    // NORM: one step per cycle. A carry is fixed in one right shift and exits
    // immediately; otherwise shift left by min(NORM_STEP, lz, exp-1).
    logic [4:0]  lz;
    logic [8:0]  amt, ne;
    logic [27:0] nm;
    logic        ndone;

    fp32_lzc u_lzc (
        .x     (ma[26:3]),
        .count (lz)
    );

    always_comb begin
        amt = 9'(NORM_STEP);
        if ({4'd0, lz} < amt) amt = {4'd0, lz};
        if ((ea - 9'd1) < amt) amt = ea - 9'd1;
        nm    = ma;
        ne    = ea;
        ndone = 1'b0;
        if (ma[27]) begin
            nm    = {1'b0, ma[27:2], ma[1] | ma[0]};
            ne    = ea + 9'd1;
            ndone = 1'b1;
        end else if (ma[26] || ea == 9'd1) begin
            ndone = 1'b1;
        end else begin
            nm = ma << amt;
            ne = ea - amt;
        end
    end

`ifdef FP32_SUB_RNE_EN
    // Round half to even on the guard bit, ties broken by the result LSB.
    logic        round_up;
    logic [24:0] rounded;
    assign round_up = ma[2] & (ma[1] | ma[0] | ma[3]);
    assign rounded  = {1'b0, ma[26:3]} + {24'd0, round_up};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            o         <= 32'd0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            ea        <= 9'd0;
            eb        <= 9'd0;
            ma        <= 28'd0;
            mb        <= 28'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (special) begin
                            o         <= special_val;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            sa    <= a[31];
                            sb    <= ~b[31];
                            ea    <= ua.exp;
                            eb    <= ub.exp;
                            ma    <= {1'b0, ua.man, 3'b000};
                            mb    <= {1'b0, ub.man, 3'b000};
                            state <= S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    ea    <= big_e;
                    ma    <= a_big ? ma : mb;
                    sa    <= a_big ? sa : sb;
                    sb    <= a_big ? sb : sa;
                    mb    <= aligned;
                    state <= S_ADDSUB;
                end
                S_ADDSUB: begin
                    if (as_res == 28'd0) begin
                        o         <= 32'd0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        ma    <= as_res;
                        sa    <= as_sign;
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    ma <= nm;
                    ea <= ne;
                    if (ndone) begin
`ifdef FP32_SUB_RNE_EN
                        state     <= S_ROUND;
`else
                        o         <= fp_pack(sa, ne, nm[26:3]);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
`endif
                    end
                end
`ifdef FP32_SUB_RNE_EN
                S_ROUND: begin
                    if (rounded[24]) o <= fp_pack(sa, ea + 9'd1, rounded[24:1]);
                    else             o <= fp_pack(sa, ea, rounded[23:0]);
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fsm_state = state;

endmodule
